// File: rtl/epd_pkg.sv
// rtl/epd_pkg.sv - shared states, byte constants and size limits for the frame checker.
// Define JUMBO_EN to raise MAX_SIZE to 9018 and widen the length counter.
package epd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DST      = 3'd2,
    ST_SRC      = 3'd3,
    ST_TYPE     = 3'd4,
    ST_BODY     = 3'd5,
    ST_DROP     = 3'd6
  } epd_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] TYPE_MIN      = 16'h0600;
  localparam logic [15:0] LEN_MAX       = 16'h05DC;
  localparam logic [2:0]  PRE_MIN       = 3'd7;
  localparam int          MIN_SIZE      = 64;

`ifdef JUMBO_EN
  localparam int MAX_SIZE = 9018;
  localparam int LEN_W    = 16;
`else
  localparam int MAX_SIZE = 1518;
  localparam int LEN_W    = 14;
`endif

  function automatic logic type_len_ok(input logic [15:0] v);
    return (v <= LEN_MAX) || (v >= TYPE_MIN);
  endfunction

endpackage

// File: rtl/epd_field_shift.sv
// rtl/epd_field_shift.sv - byte shift register for address/type fields with a per-field byte count.
// o_next_field already includes the byte on i_data so the last byte can be judged the cycle it arrives.
module epd_field_shift (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_shift_en,
  input  logic [7:0]  i_data,
  output logic [47:0] o_next_field,
  output logic [2:0]  o_byte_cnt
);

  logic [47:0] r_field;
  logic [2:0]  r_cnt;

  assign o_next_field = {r_field[39:0], i_data};
  assign o_byte_cnt   = r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_field <= '0;
      r_cnt   <= '0;
    end else if (i_shift_en) begin
      r_field <= o_next_field;
      r_cnt   <= r_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/epd_frame_checker.sv
// rtl/epd_frame_checker.sv - Ethernet frame checker: preamble/field FSM, length check, valid-frame counter.
// Define JUMBO_EN to accept frames up to 9018 bytes.
module epd_frame_checker
  import epd_pkg::*;
#(
  parameter int MIN_SIZE = epd_pkg::MIN_SIZE,
  parameter int MAX_SIZE = epd_pkg::MAX_SIZE,
  parameter int CNT_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             control,
  output logic             preamble_valid,
  output logic             dst_addr_valid,
  output logic             src_addr_valid,
  output logic             type_length_valid,
  output logic             packet_size_valid,
  output logic [CNT_W-1:0] valid_packet_counter
);

  epd_state_e       r_state;
  logic [2:0]       r_pre_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_pre_ok, r_dst_ok, r_src_ok, r_type_ok, r_size_ok;
  logic [CNT_W-1:0] r_count;

  logic        w_field_state, w_in_frame, w_shift_en, w_last_byte, w_clear;
  logic [47:0] w_next_field;
  logic [2:0]  w_byte_cnt;
  logic        w_dst_ok, w_src_ok, w_type_ok, w_size_ok, w_all_ok;
  logic [LEN_W-1:0] w_len_inc;

  assign w_field_state = (r_state == ST_DST) || (r_state == ST_SRC) || (r_state == ST_TYPE);
  assign w_in_frame    = w_field_state || (r_state == ST_BODY);
  assign w_shift_en    = w_field_state && control;
  assign w_last_byte   = w_shift_en &&
                         (w_byte_cnt == ((r_state == ST_TYPE) ? 3'd1 : 3'd5));
  // The shifter is held empty outside the header so each field starts from zero.
  assign w_clear       = !w_field_state || w_last_byte;

  epd_field_shift u_field_shift (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_clear      (w_clear),
    .i_shift_en   (w_shift_en),
    .i_data       (data),
    .o_next_field (w_next_field),
    .o_byte_cnt   (w_byte_cnt)
  );

  assign w_dst_ok  = |w_next_field;
  assign w_src_ok  = (|w_next_field) && !(&w_next_field);
  assign w_type_ok = type_len_ok(w_next_field[15:0]);
  assign w_len_inc = (&r_len) ? r_len : r_len + 1'b1;
  assign w_size_ok = (32'(r_len) >= MIN_SIZE) && (32'(r_len) <= MAX_SIZE);
  assign w_all_ok  = r_pre_ok && r_dst_ok && r_src_ok && r_type_ok && w_size_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pre_cnt <= '0;
      r_len     <= '0;
      r_pre_ok  <= 1'b0;
      r_dst_ok  <= 1'b0;
      r_src_ok  <= 1'b0;
      r_type_ok <= 1'b0;
      r_size_ok <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (control && (data == PREAMBLE_BYTE)) begin
            r_state   <= ST_PREAMBLE;
            r_pre_cnt <= 3'd1;
            r_pre_ok  <= 1'b0;
            r_dst_ok  <= 1'b0;
            r_src_ok  <= 1'b0;
            r_type_ok <= 1'b0;
            r_size_ok <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (!control) begin
            r_state   <= ST_IDLE;
            r_pre_ok  <= 1'b0;
            r_dst_ok  <= 1'b0;
            r_src_ok  <= 1'b0;
            r_type_ok <= 1'b0;
            r_size_ok <= 1'b0;
          end else if (data == PREAMBLE_BYTE) begin
            if (r_pre_cnt != PRE_MIN) r_pre_cnt <= r_pre_cnt + 3'd1;
          end else if ((data == SFD_BYTE) && (r_pre_cnt == PRE_MIN)) begin
            r_pre_ok <= 1'b1;
            r_len    <= '0;
            r_state  <= ST_DST;
          end else begin
            r_state <= ST_DROP;
          end
        end
        ST_DST, ST_SRC, ST_TYPE, ST_BODY: begin
          if (!control) begin
            r_size_ok <= w_size_ok;
            if (w_all_ok) r_count <= r_count + 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_len <= w_len_inc;
            if (w_last_byte) begin
              case (r_state)
                ST_DST: begin
                  r_dst_ok <= w_dst_ok;
                  r_state  <= ST_SRC;
                end
                ST_SRC: begin
                  r_src_ok <= w_src_ok;
                  r_state  <= ST_TYPE;
                end
                default: begin
                  r_type_ok <= w_type_ok;
                  r_state   <= ST_BODY;
                end
              endcase
            end
          end
        end
        ST_DROP: begin
          if (!control) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign preamble_valid       = r_pre_ok;
  assign dst_addr_valid       = r_dst_ok;
  assign src_addr_valid       = r_src_ok;
  assign type_length_valid    = r_type_ok;
  assign packet_size_valid    = r_size_ok;
  assign valid_packet_counter = r_count;

endmodule

// File: tb/tb_epd_frame_checker.sv
// tb/tb_epd_frame_checker.sv - scoreboard bench for epd_frame_checker.
// Honours JUMBO_EN for the oversize-frame expectation.
module tb_epd_frame_checker;

`ifdef JUMBO_EN
  localparam int MAXS = 9018;
`else
  localparam int MAXS = 1518;
`endif

  localparam logic [47:0] DST_OK  = 48'h010203040506;
  localparam logic [47:0] SRC_OK  = 48'hFFFEFDFCFBFA;
  localparam logic [15:0] TYPE_OK = 16'h0800;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       control;
  logic       preamble_valid, dst_addr_valid, src_addr_valid;
  logic       type_length_valid, packet_size_valid;
  logic [3:0] valid_packet_counter;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb[$];
  logic [7:0] fb[$];
  logic [3:0] m_cnt;
  logic [8:0] obs, expv;

  always #5 clock = ~clock;

  epd_frame_checker #(.CNT_W(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .data                 (data),
    .control              (control),
    .preamble_valid       (preamble_valid),
    .dst_addr_valid       (dst_addr_valid),
    .src_addr_valid       (src_addr_valid),
    .type_length_valid    (type_length_valid),
    .packet_size_valid    (packet_size_valid),
    .valid_packet_counter (valid_packet_counter)
  );

  assign obs = {preamble_valid, dst_addr_valid, src_addr_valid,
                type_length_valid, packet_size_valid, valid_packet_counter};

  task automatic put(input logic c, input logic [7:0] d);
    control = c;
    data    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    put(1'b0, 8'h00);
    reset = 1'b0;
    m_cnt = '0;
    sb.delete();
  endtask

  task automatic gen_frame(input int n55, input logic [47:0] dst, input logic [47:0] src,
                           input logic [15:0] typ, input int flen);
    fb.delete();
    for (int i = 0; i < n55; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) fb.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(src[i*8 +: 8]);
    fb.push_back(typ[15:8]);
    fb.push_back(typ[7:0]);
    for (int i = 14; i < flen; i++) fb.push_back((i == flen - 1) ? 8'hFF : 8'h55);
  endtask

  task automatic send_fb();
    foreach (fb[i]) put(1'b1, fb[i]);
  endtask

  // Reference model of the flags and counter after one frame end.
  task automatic push_exp(input bit pre_ok, input logic [47:0] dst, input logic [47:0] src,
                          input logic [15:0] typ, input int flen);
    bit d, s, t, z;
    d = pre_ok && (dst != 48'h0);
    s = pre_ok && (src != 48'h0) && (src != 48'hFFFF_FFFF_FFFF);
    t = pre_ok && ((typ <= 16'h05DC) || (typ >= 16'h0600));
    z = pre_ok && (flen >= 64) && (flen <= MAXS);
    if (pre_ok && d && s && t && z) m_cnt = m_cnt + 4'd1;
    sb.push_back({pre_ok, d, s, t, z, m_cnt});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    put(1'b1, 8'h55);
    put(1'b1, 8'h55);
    reset = 1'b0;
    n_tests++;
    if (obs !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, 9'h000);
    end
  endtask

  task automatic test_single();
    do_reset();
    push_exp(1'b1, DST_OK, SRC_OK, TYPE_OK, 64);
    gen_frame(7, DST_OK, SRC_OK, TYPE_OK, 64);
    send_fb();
    put(1'b0, 8'h00);
    expv = sb.pop_front();
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL single_frame: got %b expected %b", obs, expv);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push_exp(1'b1, DST_OK, SRC_OK, TYPE_OK, (f == 1) ? 139 : 64);
      gen_frame(7, DST_OK, SRC_OK, TYPE_OK, 64);
      send_fb();
      if (f == 1) begin
        for (int k = 0; k < 3; k++) put(1'b1, 8'h00);
        gen_frame(7, DST_OK, SRC_OK, TYPE_OK, 64);
        send_fb();
      end
      put(1'b0, 8'h00);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL back_to_back_%0d: scoreboard empty", f);
      end else begin
        expv = sb.pop_front();
        n_tests++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL back_to_back_%0d: got %b expected %b", f, obs, expv);
        end
      end
    end
    n_tests++;
    if (valid_packet_counter !== 4'd3) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d expected 3", valid_packet_counter);
    end
  endtask

  task automatic test_size();
    int lens[4] = '{63, 64, 1518, 1519};
    do_reset();
    foreach (lens[i]) begin
      push_exp(1'b1, DST_OK, SRC_OK, TYPE_OK, lens[i]);
      gen_frame(7, DST_OK, SRC_OK, TYPE_OK, lens[i]);
      send_fb();
      put(1'b0, 8'h00);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL size_%0d: got %b expected %b", lens[i], obs, expv);
      end
    end
  endtask

  task automatic test_preamble();
    do_reset();
    for (int v = 0; v < 3; v++) begin
      push_exp(v == 2, DST_OK, SRC_OK, TYPE_OK, 64);
      gen_frame((v == 0) ? 6 : ((v == 2) ? 9 : 7), DST_OK, SRC_OK, TYPE_OK, 64);
      if (v == 1) fb[3] = 8'h54;
      send_fb();
      put(1'b0, 8'h00);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL preamble_%0d: got %b expected %b", v, obs, expv);
      end
    end
  endtask

  task automatic test_fields();
    logic [47:0] dsts[6]  = '{DST_OK, DST_OK, 48'h0, DST_OK, DST_OK, DST_OK};
    logic [47:0] srcs[6]  = '{48'hFFFF_FFFF_FFFF, SRC_OK, SRC_OK, 48'h0, SRC_OK, SRC_OK};
    logic [15:0] types[6] = '{TYPE_OK, 16'h05E0, TYPE_OK, TYPE_OK, 16'h05DC, 16'h0600};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push_exp(1'b1, dsts[i], srcs[i], types[i], 64 + i);
      gen_frame(7, dsts[i], srcs[i], types[i], 64 + i);
      send_fb();
      put(1'b0, 8'h00);
      put(1'b0, 8'h00);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL fields_%0d: got %b expected %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push_exp(1'b1, DST_OK, SRC_OK, TYPE_OK, 64);
      gen_frame(7, DST_OK, SRC_OK, TYPE_OK, 64);
      send_fb();
      put(1'b0, 8'h00);
      expv = sb.pop_front();
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL wrap_%0d: got %b expected %b", i, obs, expv);
      end
    end
    n_tests++;
    if (valid_packet_counter !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_final: got %0d expected 0", valid_packet_counter);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_exp(1'b1, DST_OK, SRC_OK, TYPE_OK, 64);
    gen_frame(7, DST_OK, SRC_OK, TYPE_OK, 64);
    send_fb();
    put(1'b0, 8'h00);
    expv = sb.pop_front();
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got %b expected %b", obs, expv);
    end
    gen_frame(7, DST_OK, SRC_OK, TYPE_OK, 64);
    for (int i = 0; i < 30; i++) put(1'b1, fb[i]);
    reset = 1'b1;
    put(1'b1, 8'h55);
    reset = 1'b0;
    m_cnt = '0;
    n_tests++;
    if (obs !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got %b expected %b", obs, 9'h000);
    end
    put(1'b0, 8'h00);
    push_exp(1'b1, DST_OK, SRC_OK, TYPE_OK, 64);
    gen_frame(7, DST_OK, SRC_OK, TYPE_OK, 64);
    send_fb();
    put(1'b0, 8'h00);
    expv = sb.pop_front();
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL mid_reset_after: got %b expected %b", obs, expv);
    end
  endtask

  initial begin
    reset   = 1'b1;
    control = 1'b0;
    data    = 8'h00;
    m_cnt   = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_size();
    test_preamble();
    test_fields();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/epd_frame_checker.md
Name: epd_frame_checker

Overview:
- Ethernet packet detector on a byte-wide receive stream (one byte per clock, `control` high = frame byte, low = inter-frame gap).
- Checks preamble/SFD, destination, source, type/length and frame size. Counts fully valid frames.
- Sits behind the PHY/GMII-style byte interface; status flags feed monitoring logic.

Parameters:
- MIN_SIZE, 64, minimum frame length in bytes (DST through FCS inclusive).
- MAX_SIZE, 1518, maximum frame length in bytes (overridden when JUMBO_EN is defined).
- CNT_W, 4, width of valid_packet_counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- data  in  8  receive byte
- control  in  1  1 = frame byte, 0 = idle/IFG byte
- preamble_valid  out  1  seven 0x55 then 0xD5 received
- dst_addr_valid  out  1  destination address acceptable
- src_addr_valid  out  1  source address acceptable
- type_length_valid  out  1  type/length field acceptable
- packet_size_valid  out  1  frame length within [MIN_SIZE, MAX_SIZE]
- valid_packet_counter  out  CNT_W  count of fully valid frames

Behaviour:
- One clock domain (`clock`); reset is synchronous and active-high on `reset`. On reset, all flags are 0, the counter is 0 and the FSM is in IDLE.
- FSM states: IDLE, PREAMBLE, DST, SRC, TYPE, BODY, DROP. All transitions are evaluated on the rising edge of `clock`.
- IDLE:
  - Sampling control=1 with data=0x55 loads the preamble count to 1 and moves to PREAMBLE.
  - Any other byte keeps the FSM in IDLE (hunting).
- PREAMBLE:
  - 0x55 increments the count.
  - 0xD5 arriving when the count is 7 or more sets preamble_valid the next cycle and moves to DST.
  - Any other byte, or control=0, moves to DROP/IDLE.
- Field checks:
  - DST is 6 bytes. It is valid if it is not all-zero.
  - SRC is 6 bytes. It is valid if it is neither all-zero nor 0xFFFFFFFFFFFF.
  - TYPE is 2 bytes, big-endian. It is valid if the value is ≤0x05DC or ≥0x0600.
  - Each flag updates on the cycle after the field's last byte.
  - An invalid field does not abort the frame; its flag simply stays 0.
- BODY accepts any bytes until control samples 0.
- Frame length:
  - Counts bytes from the first DST byte through the last control=1 byte.
  - The counter saturates at 2^14-1.
- Frame end is the first control=0 sample after DST has started. On that cycle:
  - packet_size_valid is registered from the length check.
  - If all five flags are 1, valid_packet_counter increments. It wraps from 15 to 0.
  - The FSM returns to IDLE.
- A missing IFG means control never drops between frames. The following bytes are absorbed as body of the current frame, so the two frames merge into one. The merged frame is judged on the merged length.
- A control=0 byte before DST is reached returns the FSM to IDLE and clears the flags with no count. DROP waits for control=0 before returning to IDLE.
- Flag lifetime: flags hold their value through the IFG. All five are cleared when a new PREAMBLE is entered.
- Reset mid-frame aborts the frame with no count.

Optional Feature:
- JUMBO_EN defined: MAX_SIZE becomes 9018 and the length counter is wide enough not to saturate below it.
- JUMBO_EN undefined: frames longer than 1518 bytes give packet_size_valid=0.

Decomposition:
- Package epd_pkg holds:
  - the FSM state enum;
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, MIN_SIZE, MAX_SIZE, TYPE_MIN=0x0600, LEN_MAX=0x05DC.
- One sub-module, epd_field_shift, holds the 48-bit address / 16-bit type shift register with a byte counter. The FSM and counters stay in the top level.

Test Plan:
- Single frame: 7×0x55, 0xD5, DST 01..06, SRC FF FE FD FC FB FA, type 0x0800, 49×0x55 plus 0xFF, then one control=0 byte → all five flags 1, counter = 1.
- Four 64-byte frames, each followed by one IFG byte, except frames 2 and 3, which are separated by 3 bytes of 0x00 with control held high → frames 2 and 3 merge (139 bytes, valid); final counter = 3.
- 63-byte frame → packet_size_valid = 0, counter unchanged. 1519-byte frame → packet_size_valid = 0 without JUMBO_EN and 1 with it.
- Preamble with only 6×0x55 before 0xD5, or 0x54 in the middle → preamble_valid = 0, no count.
- SRC = FF×6 or type 0x05E0 → corresponding flag = 0, counter unchanged. 16 valid frames → counter wraps to 0.
- reset asserted mid-payload → flags and counter 0 on the next edge. The next valid frame gives counter = 1.
